hash_query_ctrl: RTL and testbench

Initiator side of the IPv4 hash-table query interface in the 1G Ethernet parser.
- Accepts insert/lookup requests carrying a 32-bit IPv4 address.
- Folds the address into a 12-bit table key.
- Drives the table's query, key, value and write-enable inputs, then samples the table's 1-bit response.
- Returns one hit/success result per request over a valid/ready handshake.
- Sits between the header-parse stage (upstream) and the hash table.

---
 rtl/hash_query_ctrl_pkg.sv | 29 ++
 rtl/hash_query_ctrl_key_fold.sv | 32 +++
 rtl/hash_query_ctrl.sv | 143 ++++++++++++++
 tb/tb_hash_query_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_query_ctrl_pkg.sv
// hash_query_ctrl_pkg
//   Shared types and widths for the IPv4 hash-table query path.
//   hash_query_t : query type driven to the table (INSERT_QUERY / LOOK_UP_QUERY)
//   hqc_state_t  : controller FSM states; the DUP_* states exist only when
//                  HASH_DUP_CHECK_EN is defined.
package hash_query_ctrl_pkg;

  localparam int unsigned IPV4_IP_W  = 32;
  localparam int unsigned HASH_KEY_W = 12;

  typedef enum logic {
    INSERT_QUERY  = 1'b0,
    LOOK_UP_QUERY = 1'b1
  } hash_query_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CHECK,
    ST_WRITE,
    ST_RESP
`ifdef HASH_DUP_CHECK_EN
    ,
    ST_DUP_ISSUE,
    ST_DUP_CHECK
`endif
  } hqc_state_t;

endpackage

// File: rtl/hash_query_ctrl_key_fold.sv
// hash_key_fold
//   Combinational XOR fold of a VAL_W value into a KEY_W table key. The value
//   is zero-extended to a whole number of KEY_W chunks and all chunks are
//   XORed together; for 32 -> 12 this is ip[11:0] ^ ip[23:12] ^ {4'b0, ip[31:24]}.
//   Ports:
//     val : input value (IPv4 address)
//     key : folded table key
module hash_key_fold
  import hash_query_ctrl_pkg::*;
#(
  parameter int unsigned VAL_W = IPV4_IP_W,
  parameter int unsigned KEY_W = HASH_KEY_W
) (
  input  logic [VAL_W-1:0] val,
  output logic [KEY_W-1:0] key
);

  localparam int unsigned NCHUNK = (VAL_W + KEY_W - 1) / KEY_W;
  localparam int unsigned PAD_W  = NCHUNK * KEY_W;

  logic [PAD_W-1:0] padded;

  assign padded = PAD_W'(val);

  always_comb begin
    key = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      key = key ^ padded[i*KEY_W +: KEY_W];
    end
  end

endmodule

// File: rtl/hash_query_ctrl.sv
// hash_query_ctrl
//   Initiator side of the IPv4 hash-table query interface. Accepts one
//   insert/lookup request at a time, folds the address into a table key,
//   queries the table, optionally writes it, and returns a hit/success result.
//   Optional build macro: HASH_DUP_CHECK_EN -- an insert that finds its slot
//   occupied re-queries the slot as a lookup, so re-inserting an address that
//   is already stored reports success instead of a collision.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     req_valid_i/req_ready_o       : request handshake
//     req_op_i, req_ip_i            : request op and IPv4 address
//     ht_query_o, ht_key_o, ht_val_o: table query type, key, value
//     ht_wr_en_o                    : table write strobe
//     ht_resp_i                     : table response, valid the cycle after issue
//     rsp_valid_o/rsp_ready_i       : result handshake
//     rsp_op_o, rsp_hit_o           : echoed op and hit/success flag
//     ins_fail_cnt_o                : saturating count of failed inserts
module hash_query_ctrl
  import hash_query_ctrl_pkg::*;
#(
  parameter int unsigned KEY_W = HASH_KEY_W,
  parameter int unsigned VAL_W = IPV4_IP_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  hash_query_t        req_op_i,
  input  logic [VAL_W-1:0]   req_ip_i,
  output hash_query_t        ht_query_o,
  output logic [KEY_W-1:0]   ht_key_o,
  output logic [VAL_W-1:0]   ht_val_o,
  output logic               ht_wr_en_o,
  input  logic               ht_resp_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output hash_query_t        rsp_op_o,
  output logic               rsp_hit_o,
  output logic [CNT_W-1:0]   ins_fail_cnt_o
);

  hqc_state_t       state;
  hash_query_t      op_q;
  logic [KEY_W-1:0] fold_key;

  hash_key_fold #(
    .VAL_W (VAL_W),
    .KEY_W (KEY_W)
  ) u_fold (
    .val (req_ip_i),
    .key (fold_key)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // ht_key_o/ht_val_o double as the request registers: they are loaded at
  // accept so the table sees them during ISSUE and they stay put afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      op_q           <= LOOK_UP_QUERY;
      req_ready_o    <= 1'b1;
      ht_wr_en_o     <= 1'b0;
      ht_query_o     <= LOOK_UP_QUERY;
      ht_key_o       <= '0;
      ht_val_o       <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_hit_o      <= 1'b0;
      rsp_op_o       <= LOOK_UP_QUERY;
      ins_fail_cnt_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            op_q        <= req_op_i;
            rsp_op_o    <= req_op_i;
            if (req_op_i == INSERT_QUERY && req_ip_i == '0) begin
              // address 0 marks an empty slot and can never be stored
              rsp_hit_o      <= 1'b0;
              rsp_valid_o    <= 1'b1;
              ins_fail_cnt_o <= sat_inc(ins_fail_cnt_o);
              state          <= ST_RESP;
            end else begin
              ht_query_o <= req_op_i;
              ht_key_o   <= fold_key;
              ht_val_o   <= req_ip_i;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_CHECK;
        ST_CHECK: begin
          if (op_q == LOOK_UP_QUERY) begin
            rsp_hit_o   <= ht_resp_i;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else if (ht_resp_i) begin
            ht_wr_en_o <= 1'b1;
            state      <= ST_WRITE;
          end else begin
`ifdef HASH_DUP_CHECK_EN
            ht_query_o <= LOOK_UP_QUERY;
            state      <= ST_DUP_ISSUE;
`else
            rsp_hit_o      <= 1'b0;
            rsp_valid_o    <= 1'b1;
            ins_fail_cnt_o <= sat_inc(ins_fail_cnt_o);
            state          <= ST_RESP;
`endif
          end
        end
        ST_WRITE: begin
          ht_wr_en_o  <= 1'b0;
          rsp_hit_o   <= 1'b1;
          rsp_valid_o <= 1'b1;
          state       <= ST_RESP;
        end
`ifdef HASH_DUP_CHECK_EN
        ST_DUP_ISSUE: state <= ST_DUP_CHECK;
        ST_DUP_CHECK: begin
          rsp_hit_o   <= ht_resp_i;
          rsp_valid_o <= 1'b1;
          if (!ht_resp_i) ins_fail_cnt_o <= sat_inc(ins_fail_cnt_o);
          state       <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_query_ctrl.sv
// tb_hash_query_ctrl
//   Self-checking bench for hash_query_ctrl: a behavioural hash table drives
//   ht_resp_i, directed vectors cover the documented scenarios, and random
//   requests are checked against a reference model of the request rules.
//   The counter is built narrow so saturation is reachable.
module tb_hash_query_ctrl;
  import hash_query_ctrl_pkg::*;

  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef HASH_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  hash_query_t   req_op = LOOK_UP_QUERY;
  logic [31:0]   req_ip = '0;
  hash_query_t   ht_query;
  logic [11:0]   ht_key;
  logic [31:0]   ht_val;
  logic          ht_wr_en;
  logic          ht_resp = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  hash_query_t   rsp_op;
  logic          rsp_hit;
  logic [CW-1:0] cnt;

  hash_query_ctrl #(
    .KEY_W (12),
    .VAL_W (32),
    .CNT_W (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_ip_i       (req_ip),
    .ht_query_o     (ht_query),
    .ht_key_o       (ht_key),
    .ht_val_o       (ht_val),
    .ht_wr_en_o     (ht_wr_en),
    .ht_resp_i      (ht_resp),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_op_o       (rsp_op),
    .rsp_hit_o      (rsp_hit),
    .ins_fail_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  // Behavioural table: 0 = empty slot. Insert query answers "slot empty",
  // lookup answers "slot holds this value". Response registered one cycle.
  logic [31:0] tmem [4096] = '{default: '0};
  int          wr_cnt = 0;
  logic [11:0] wr_key = '0;
  logic [31:0] wr_val = '0;

  always @(posedge clk) begin
    if (ht_query == INSERT_QUERY) ht_resp <= (tmem[ht_key] == 32'd0);
    else ht_resp <= (tmem[ht_key] != 32'd0) && (tmem[ht_key] == ht_val);
    if (ht_wr_en) begin
      tmem[ht_key] = ht_val;
      wr_cnt = wr_cnt + 1;
      wr_key = ht_key;
      wr_val = ht_val;
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // reference model state
  logic [31:0] rmem [4096] = '{default: '0};
  int rcnt = 0;

  function automatic logic [11:0] ref_key(input logic [31:0] ip);
    return ip[11:0] ^ ip[23:12] ^ {4'b0000, ip[31:24]};
  endfunction

  int          wr_base;
  logic [11:0] pre_key;
  logic [31:0] pre_val;

  // Issue one request, measure accept-to-valid latency, hold rsp_ready low
  // for 'hold' cycles checking stability, then complete the handshake.
  task automatic run_req(input hash_query_t op, input logic [31:0] ip, input int hold,
                         input logic exp_hit, output logic hit, output int lat,
                         output hash_query_t rop);
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("req_ready_before_req", req_ready, 1);
    pre_key = ht_key;
    pre_val = ht_val;
    wr_base = wr_cnt;
    req_valid = 1'b1; req_op = op; req_ip = ip;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    hit = rsp_hit;
    rop = rsp_op;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_hit", rsp_hit, exp_hit);
      check("hold_op", rsp_op, op);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("valid_drops", rsp_valid, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_wr_en"}, ht_wr_en, 0);
    check({tag, "_query"}, ht_query, LOOK_UP_QUERY);
    check({tag, "_key"}, ht_key, 0);
    check({tag, "_val"}, ht_val, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_hit"}, rsp_hit, 0);
    check({tag, "_rsp_op"}, rsp_op, LOOK_UP_QUERY);
    check({tag, "_cnt"}, cnt, 0);
  endtask

  typedef struct {
    hash_query_t op;
    logic [31:0] ip;
    int          hold;
    logic        exp_hit;
    int          exp_lat;
    int          exp_wr;
    int          exp_cnt;
    logic [11:0] exp_key;
    bit          no_query;
  } vec_t;

  vec_t        vecs [6];
  logic        hit;
  int          lat;
  hash_query_t rop;

  initial begin
    vecs[0] = '{LOOK_UP_QUERY, 32'hC0A80101, 0, 1'b0, 2, 0, 0, 12'hB41, 1'b0};
    vecs[1] = '{INSERT_QUERY,  32'hC0A80101, 0, 1'b1, 3, 1, 0, 12'hB41, 1'b0};
    vecs[2] = '{LOOK_UP_QUERY, 32'hC0A80101, 1, 1'b1, 2, 0, 0, 12'hB41, 1'b0};
    vecs[3] = '{INSERT_QUERY,  32'h00000B41, 0, 1'b0, DUP ? 4 : 2, 0, 1, 12'hB41, 1'b0};
    vecs[4] = '{INSERT_QUERY,  32'hC0A80101, 0, DUP, DUP ? 4 : 2, 0, DUP ? 1 : 2, 12'hB41, 1'b0};
    vecs[5] = '{INSERT_QUERY,  32'h00000000, 5, 1'b0, 0, 0, DUP ? 2 : 3, 12'h000, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    foreach (vecs[v]) begin
      run_req(vecs[v].op, vecs[v].ip, vecs[v].hold, vecs[v].exp_hit, hit, lat, rop);
      check($sformatf("v%0d_hit", v), hit, vecs[v].exp_hit);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_op", v), rop, vecs[v].op);
      check($sformatf("v%0d_writes", v), wr_cnt - wr_base, vecs[v].exp_wr);
      check($sformatf("v%0d_cnt", v), cnt, vecs[v].exp_cnt);
      if (vecs[v].no_query) begin
        check($sformatf("v%0d_key_untouched", v), ht_key, pre_key);
        check($sformatf("v%0d_val_untouched", v), ht_val, pre_val);
      end else begin
        check($sformatf("v%0d_key", v), ht_key, vecs[v].exp_key);
        check($sformatf("v%0d_val", v), ht_val, vecs[v].ip);
      end
      if (vecs[v].exp_wr != 0) begin
        check($sformatf("v%0d_wr_key", v), wr_key, vecs[v].exp_key);
        check($sformatf("v%0d_wr_val", v), wr_val, vecs[v].ip);
      end
    end
    check("lookup_query_type", vecs[0].op == LOOK_UP_QUERY ? 1 : 0, 1);
    rmem[12'hB41] = 32'hC0A80101;

    // reset while an insert bound for WRITE sits in CHECK (key 0x32F is empty)
    wr_base = wr_cnt;
    req_valid = 1'b1; req_op = INSERT_QUERY; req_ip = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("mid_reset");
    @(posedge clk); #1;
    check("mid_reset_no_write", wr_cnt - wr_base, 0);
    check("mid_reset_no_rsp", rsp_valid, 0);
    rcnt = 0;
    run_req(LOOK_UP_QUERY, 32'h12345678, 0, 1'b0, hit, lat, rop);
    check("dropped_insert_absent", hit, 0);

    // counter saturation via zero-address inserts
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      run_req(INSERT_QUERY, 32'h0, 0, 1'b0, hit, lat, rop);
      rcnt = (rcnt < CNT_MAX) ? rcnt + 1 : rcnt;
      check($sformatf("sat_cnt_%0d", i), cnt, rcnt);
    end

    // random requests over a small address space to force collisions
    for (int r = 0; r < 60; r++) begin
      hash_query_t op;
      logic [31:0] ip;
      logic [11:0] k;
      logic        ehit;
      int          elat, ewr, hold;
      bit          fail;
      op = ($urandom_range(0, 1) == 0) ? INSERT_QUERY : LOOK_UP_QUERY;
      ip = ($urandom_range(0, 3) << 24) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      k = ref_key(ip);
      ewr = 0; fail = 1'b0;
      if (op == LOOK_UP_QUERY) begin
        ehit = (rmem[k] != 0) && (rmem[k] == ip); elat = 2;
      end else if (ip == 0) begin
        ehit = 1'b0; elat = 0; fail = 1'b1;
      end else if (rmem[k] == 0) begin
        ehit = 1'b1; elat = 3; ewr = 1; rmem[k] = ip;
      end else if (DUP && rmem[k] == ip) begin
        ehit = 1'b1; elat = 4;
      end else begin
        ehit = 1'b0; elat = DUP ? 4 : 2; fail = 1'b1;
      end
      if (fail && rcnt < CNT_MAX) rcnt++;
      run_req(op, ip, hold, ehit, hit, lat, rop);
      check($sformatf("r%0d_hit", r), hit, ehit);
      check($sformatf("r%0d_latency", r), lat, elat);
      check($sformatf("r%0d_writes", r), wr_cnt - wr_base, ewr);
      check($sformatf("r%0d_cnt", r), cnt, rcnt);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
